// File: rtl/register_32b1.sv
// Quotient capture register for the structural divider, built bit-by-bit from
// dFlipFlop cells; the mux leaf cell lives here too since the divider reuses both.

module dFlipFlop (
    input  logic d,
    input  logic clk,
    input  logic reset,
    output logic q
);

    // Reset wins over data; both are only looked at on the rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

module mux (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = sel ? a : b;

endmodule

module register_32b1 (
    input  logic [31:0] d,
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] q
);

    // clk may be the divider's capture strobe rather than a free-running clock;
    // there is no load enable, so every rising edge captures the whole word.
    for (genvar i = 0; i < 32; i++) begin : gBit
        dFlipFlop bitCell (
            .d    (d[i]),
            .clk  (clk),
            .reset(reset),
            .q    (q[i])
        );
    end

endmodule

// File: tb/tb_register_32b1.sv
// Directed bench for register_32b1, plus standalone dFlipFlop (toggle, ripple
// counter) and exhaustive mux checks.

module tb_register_32b1;

    logic        clk;
    logic        reset;
    logic [31:0] d;
    logic [31:0] q;

    int nAsserts;
    int nFail;

    register_32b1 dut (
        .d    (d),
        .clk  (clk),
        .reset(reset),
        .q    (q)
    );

    // Toggle flop: d = ~q.
    logic togReset;
    logic togQ;
    dFlipFlop togCell (
        .d    (~togQ),
        .clk  (clk),
        .reset(togReset),
        .q    (togQ)
    );

    // Six-stage ripple counter. While rcInit is high every stage is clocked by
    // clk so a synchronous reset reaches all of them.
    logic rcInit;
    logic rcReset;
    logic rcQ   [6];
    logic rcClk [6];
    assign rcClk[0] = clk;

    dFlipFlop rcCell0 (
        .d    (~rcQ[0]),
        .clk  (rcClk[0]),
        .reset(rcReset),
        .q    (rcQ[0])
    );

    for (genvar i = 1; i < 6; i++) begin : gRipple
        mux stageSel (
            .a  (clk),
            .b  (~rcQ[i-1]),
            .sel(rcInit),
            .y  (rcClk[i])
        );
        dFlipFlop rcCell (
            .d    (~rcQ[i]),
            .clk  (rcClk[i]),
            .reset(rcReset),
            .q    (rcQ[i])
        );
    end

    // Standalone mux for exhaustive checking.
    logic ma, mb, ms, my;
    mux muxCell (
        .a  (ma),
        .b  (mb),
        .sel(ms),
        .y  (my)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full clock period; returns with clk low, well away from the edge.
    task automatic pulse();
        #4 clk = 1'b1;
        #4 clk = 1'b0;
    endtask

    function automatic logic [31:0] rcValue();
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < 6; k++) v[k] = rcQ[k];
        return v;
    endfunction

    initial begin
        logic [7:0]  muxTab;
        logic [2:0]  idx;
        logic [31:0] walk;

        nAsserts = 0;
        nFail    = 0;
        clk      = 1'b0;
        reset    = 1'b1;
        d        = 32'hFFFF_FFFF;
        togReset = 1'b1;
        rcInit   = 1'b1;
        rcReset  = 1'b1;
        ma = 1'b0; mb = 1'b0; ms = 1'b0;

        // Reset has priority over all-ones data.
        pulse();
        check("reset_clears", q, 32'h0000_0000);
        reset = 1'b0;
        pulse();
        check("release_captures", q, 32'hFFFF_FFFF);

        // Capture and hold between edges.
        d = 32'h0108_00FF;
        pulse();
        check("capture_a", q, 32'h0108_00FF);
        d = 32'h1234_5678;
        #3;
        check("hold_mid_cycle", q, 32'h0108_00FF);
        pulse();
        check("capture_b", q, 32'h1234_5678);

        // Walking one across every bit.
        for (int i = 0; i < 32; i++) begin
            walk = 32'h0000_0001 << i;
            d = walk;
            pulse();
            check($sformatf("walk_%0d", i), q, walk);
        end

        // Reset asserted between edges does nothing until the next rising edge.
        d = 32'hA5A5_5A5A;
        pulse();
        check("pre_reset_value", q, 32'hA5A5_5A5A);
        reset = 1'b1;
        #2;
        check("reset_waits_for_edge", q, 32'hA5A5_5A5A);
        pulse();
        check("reset_mid_operation", q, 32'h0000_0000);
        reset = 1'b0;

        // Derived strobe: high 10, low 4, rise again.
        d = 32'hDEAD_BEEF;
        #4 clk = 1'b1;
        #1;
        check("strobe_rise_1", q, 32'hDEAD_BEEF);
        d = 32'hCAFE_F00D;
        #9;
        check("strobe_high_hold", q, 32'hDEAD_BEEF);
        clk = 1'b0;
        #2;
        check("strobe_fall_no_effect", q, 32'hDEAD_BEEF);
        #2 clk = 1'b1;
        #1;
        check("strobe_rise_2", q, 32'hCAFE_F00D);
        #3 clk = 1'b0;
        #2;
        check("strobe_one_capture", q, 32'hCAFE_F00D);

        // Toggle flop: reset pulsed at the first edge, then 1,0,1.
        togReset = 1'b1;
        pulse();
        check("toggle_0", {31'b0, togQ}, 32'd0);
        togReset = 1'b0;
        pulse();
        check("toggle_1", {31'b0, togQ}, 32'd1);
        pulse();
        check("toggle_2", {31'b0, togQ}, 32'd0);
        pulse();
        check("toggle_3", {31'b0, togQ}, 32'd1);

        // Ripple counter: all stages were held in reset; hand clocking over
        // to the ripple chain while still in reset, then release.
        rcInit = 1'b0;
        #1;
        rcReset = 1'b0;
        #1;
        check("ripple_start", rcValue(), 32'd0);
        for (int n = 1; n <= 40; n++) begin
            pulse();
            check($sformatf("ripple_%0d", n), rcValue(), 32'(n));
        end

        // Mux truth table, bit index = {a,b,sel}.
        muxTab = 8'hE4;
        for (int k = 0; k < 8; k++) begin
            idx = 3'(k);
            {ma, mb, ms} = idx;
            #1;
            check($sformatf("mux_%0d", k), {31'b0, my}, {31'b0, muxTab[idx]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
